spi_ram_arbiter: RTL and testbench

Two-port arbiter that shares the single memory-mapped SPI RAM controller between the FemtoRV32 CPU data port (requester 0) and a second bus master such as a UART loader or DMA engine (requester 1). Each requester sees the same strobe/busy/rdata protocol the CPU already uses. The arbiter latches single-cycle requests, serialises them onto the controller and returns read data per requester. It sits between the address decoder's `cs[6]`-qualified strobes and the SPI RAM controller.

---
 rtl/spi_ram_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one SPI RAM controller between two bus masters.
//   Requester 0 is the CPU data port, requester 1 a secondary master (UART
//   loader / DMA). Single-cycle rd/wr strobes are latched into per-requester
//   pending slots and serialised onto the controller one at a time.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   reqN_addr/wdata/rd/wr       requester N strobe interface (N = 0, 1)
//   reqN_rbusy/wbusy/rdata      requester N status and last read result
//   ram_addr/wdata/rd/wr        command to the SPI RAM controller
//   ram_rbusy/wbusy/rdata       controller status and read data
//
// Build option:
//   SPI_ARB_ROUND_ROBIN_EN  defined: ties go to the requester not granted last.
//                           undefined: requester 0 always wins ties.
module spi_ram_arbiter #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_rd,
  input  logic          req0_wr,
  output logic          req0_rbusy,
  output logic          req0_wbusy,
  output logic [DW-1:0] req0_rdata,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_rd,
  input  logic          req1_wr,
  output logic          req1_rbusy,
  output logic          req1_wbusy,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rd,
  output logic          ram_wr,
  input  logic          ram_rbusy,
  input  logic          ram_wbusy,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT0    = 3'd2,
    S_WAIT     = 3'd3,
    S_COMPLETE = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Requester inputs gathered into indexable form
  logic [1:0]    req_rd;
  logic [1:0]    req_wr;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];

  assign req_rd       = {req1_rd, req0_rd};
  assign req_wr       = {req1_wr, req0_wr};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  logic [1:0]    slot_valid_q, slot_valid_d;
  logic [1:0]    slot_wr_q, slot_wr_d;
  logic [AW-1:0] slot_addr_q  [2];
  logic [AW-1:0] slot_addr_d  [2];
  logic [DW-1:0] slot_wdata_q [2];
  logic [DW-1:0] slot_wdata_d [2];
  logic [1:0]    rbusy_q, wbusy_q;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_rd_q, ram_rd_d;
  logic          ram_wr_q, ram_wr_d;
  logic          grant_q, grant_d;
  logic          sel;
  logic          complete;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  assign complete = (state_q == S_COMPLETE);

  // Winner among currently valid slots
  always_comb begin : winner_sel
`ifdef SPI_ARB_ROUND_ROBIN_EN
    if (slot_valid_q[0] && slot_valid_q[1]) sel = ~last_q;
    else                                    sel = slot_valid_q[1];
`else
    sel = ~slot_valid_q[0];
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin : state_reg
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; WAIT0 deliberately ignores busy while it rises
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (|slot_valid_q) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT0;
      S_WAIT0:    state_d = S_WAIT;
      S_WAIT:     if (!(ram_rbusy || ram_wbusy)) state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant capture, controller command, read-data return
  always_comb begin : fsm_outputs
    grant_d     = grant_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    rdata_d[0]  = rdata_q[0];
    rdata_d[1]  = rdata_q[1];
`ifdef SPI_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    // Strobe is registered so it is high exactly in the ISSUE cycle
    if (state_q == S_IDLE && (|slot_valid_q)) begin
      grant_d     = sel;
      ram_addr_d  = slot_addr_q[sel];
      ram_wdata_d = slot_wdata_q[sel];
      ram_rd_d    = ~slot_wr_q[sel];
      ram_wr_d    = slot_wr_q[sel];
`ifdef SPI_ARB_ROUND_ROBIN_EN
      last_d      = sel;
`endif
    end
    if (complete && !slot_wr_q[grant_q]) rdata_d[grant_q] = ram_rdata;
  end

  // Pending slots: completion clears the winner, an empty slot takes a strobe
  always_comb begin : slot_next
    for (int n = 0; n < 2; n++) begin
      slot_valid_d[n] = slot_valid_q[n];
      slot_wr_d[n]    = slot_wr_q[n];
      slot_addr_d[n]  = slot_addr_q[n];
      slot_wdata_d[n] = slot_wdata_q[n];
      if (complete && grant_q == 1'(n)) begin
        slot_valid_d[n] = 1'b0;
      end else if (!slot_valid_q[n] && (req_rd[n] || req_wr[n])) begin
        slot_valid_d[n] = 1'b1;
        slot_wr_d[n]    = req_wr[n];
        slot_addr_d[n]  = req_addr[n];
        slot_wdata_d[n] = req_wdata[n];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin : data_reg
    if (!resetn) begin
      slot_valid_q    <= '0;
      slot_wr_q       <= '0;
      slot_addr_q[0]  <= '0;
      slot_addr_q[1]  <= '0;
      slot_wdata_q[0] <= '0;
      slot_wdata_q[1] <= '0;
      rbusy_q         <= '0;
      wbusy_q         <= '0;
      rdata_q[0]      <= '0;
      rdata_q[1]      <= '0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
      ram_rd_q        <= 1'b0;
      ram_wr_q        <= 1'b0;
      grant_q         <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      last_q          <= 1'b1;
`endif
    end else begin
      slot_valid_q    <= slot_valid_d;
      slot_wr_q       <= slot_wr_d;
      slot_addr_q[0]  <= slot_addr_d[0];
      slot_addr_q[1]  <= slot_addr_d[1];
      slot_wdata_q[0] <= slot_wdata_d[0];
      slot_wdata_q[1] <= slot_wdata_d[1];
      rbusy_q         <= slot_valid_d & ~slot_wr_d;
      wbusy_q         <= slot_valid_d & slot_wr_d;
      rdata_q[0]      <= rdata_d[0];
      rdata_q[1]      <= rdata_d[1];
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
      ram_rd_q        <= ram_rd_d;
      ram_wr_q        <= ram_wr_d;
      grant_q         <= grant_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      last_q          <= last_d;
`endif
    end
  end

  assign req0_rbusy = rbusy_q[0];
  assign req0_wbusy = wbusy_q[0];
  assign req0_rdata = rdata_q[0];
  assign req1_rbusy = rbusy_q[1];
  assign req1_wbusy = wbusy_q[1];
  assign req1_rdata = rdata_q[1];
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr     = ram_wr_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: transaction-timing model plus directed scenarios.
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [19:0] req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic        req0_rbusy, req0_wbusy, req1_rbusy, req1_wbusy;
  logic [31:0] req0_rdata, req1_rdata;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rd, ram_wr;
  logic        ram_rbusy, ram_wbusy;
  logic [31:0] ram_rdata;

  spi_ram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rd(req0_rd), .req0_wr(req0_wr),
    .req0_rbusy(req0_rbusy), .req0_wbusy(req0_wbusy), .req0_rdata(req0_rdata),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rd(req1_rd), .req1_wr(req1_wr),
    .req1_rbusy(req1_rbusy), .req1_wbusy(req1_wbusy), .req1_rdata(req1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- controller model ----------------
  int          bcnt;
  bit          bwr;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          lg_cyc[$];
  logic [19:0] lg_addr[$];
  bit          lg_wr[$];
  logic [31:0] lg_data[$];
  logic [31:0] cmem [logic [19:0]];

  assign ram_rbusy = (bcnt != 0) && !bwr;
  assign ram_wbusy = (bcnt != 0) && bwr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt <= 0;
      bwr  <= 1'b0;
    end else begin
      if (bcnt != 0) bcnt <= bcnt - 1;
      if (ram_rd || ram_wr) begin
        bcnt <= lat;
        bwr  <= ram_wr;
        lg_cyc.push_back(cyc);
        lg_addr.push_back(ram_addr);
        lg_wr.push_back(ram_wr);
        lg_data.push_back(ram_wdata);
        if (ram_wr) begin
          cmem[ram_addr] = ram_wdata;
          wr_pulses++;
        end else begin
          ram_rdata <= cmem.exists(ram_addr) ? cmem[ram_addr] : {12'hC0D, ram_addr};
          rd_pulses++;
        end
      end
    end
  end

  // ---------------- arbiter model ----------------
  // A grant in cycle g issues at g+1; the request completes at g+max(4,3+L)
  // and the next grant may happen the cycle after completion.
  logic        m_v[2], m_w[2];
  logic [19:0] m_a[2];
  logic [31:0] m_d[2];
  logic        e_rd, e_wr;
  logic [19:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata[2];
  int          m_free, m_cmp, m_win, m_last;
  logic        pv0, pv1;
  logic [31:0] mmem [logic [19:0]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 2; n++) begin
        m_v[n] = 1'b0; m_w[n] = 1'b0; m_a[n] = '0; m_d[n] = '0; e_rdata[n] = '0;
      end
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      m_free = 0; m_cmp = -1; m_win = 0; m_last = 1;
    end else begin
      pv0 = m_v[0];
      pv1 = m_v[1];
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (cyc == m_cmp) begin
        m_v[m_win] = 1'b0;
        if (!m_w[m_win])
          e_rdata[m_win] = mmem.exists(m_a[m_win]) ? mmem[m_a[m_win]] : {12'hC0D, m_a[m_win]};
      end
      if (cyc >= m_free && (pv0 || pv1)) begin
        if (pv0 && pv1) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
          m_win = 1 - m_last;
`else
          m_win = 0;
`endif
        end else begin
          m_win = pv0 ? 0 : 1;
        end
        m_last  = m_win;
        e_rd    = !m_w[m_win];
        e_wr    = m_w[m_win];
        e_addr  = m_a[m_win];
        e_wdata = m_d[m_win];
        if (m_w[m_win]) mmem[m_a[m_win]] = m_d[m_win];
        m_cmp  = cyc + ((lat > 1) ? 3 + lat : 4);
        m_free = m_cmp + 1;
      end
      if (!pv0 && (req0_rd || req0_wr)) begin
        m_v[0] = 1'b1; m_w[0] = req0_wr; m_a[0] = req0_addr; m_d[0] = req0_wdata;
      end
      if (!pv1 && (req1_rd || req1_wr)) begin
        m_v[1] = 1'b1; m_w[1] = req1_wr; m_a[1] = req1_addr; m_d[1] = req1_wdata;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("req0_rbusy", {31'b0, req0_rbusy}, {31'b0, m_v[0] && !m_w[0]});
      check("req0_wbusy", {31'b0, req0_wbusy}, {31'b0, m_v[0] && m_w[0]});
      check("req1_rbusy", {31'b0, req1_rbusy}, {31'b0, m_v[1] && !m_w[1]});
      check("req1_wbusy", {31'b0, req1_wbusy}, {31'b0, m_v[1] && m_w[1]});
      check("req0_rdata", req0_rdata, e_rdata[0]);
      check("req1_rdata", req1_rdata, e_rdata[1]);
      check("ram_rd", {31'b0, ram_rd}, {31'b0, e_rd});
      check("ram_wr", {31'b0, ram_wr}, {31'b0, e_wr});
      check("ram_addr", {12'b0, ram_addr}, {12'b0, e_addr});
      check("ram_wdata", ram_wdata, e_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r0, input logic w0, input logic [19:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [19:0] a1, input logic [31:0] d1,
                       output int t);
    @(posedge clk); #1;
    req0_rd = r0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
    req1_rd = r1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    t = cyc;
    @(posedge clk); #1;
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((m_v[0] || m_v[1] || cyc < m_free) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, {31'b0, n >= 300}, 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic int who(input logic [19:0] a);
    return (a >= 20'h200) ? 1 : 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, i0, rp, wp;
    int exp_b, exp_c;
    resetn = 1'b0;
    req0_rd = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_rd = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
    cmem[20'h10] = 32'hDEADBEEF;
    mmem[20'h10] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_req0_rbusy", {31'b0, req0_rbusy}, 32'd0);
    check("reset_ram_rd", {31'b0, ram_rd}, 32'd0);
    check("reset_ram_addr", {12'b0, ram_addr}, 32'd0);
    check("reset_req1_rdata", req1_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single read, controller busy 4 cycles
    lat = 4;
    drive(1'b1, 1'b0, 20'h10, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, t);
    goto(t + 1); check("rd_busy_t1", {31'b0, req0_rbusy}, 32'd1);
    goto(t + 2); check("rd_pulse_t2", {31'b0, ram_rd}, 32'd1);
                 check("rd_addr_t2", {12'b0, ram_addr}, 32'h10);
    goto(t + 3); check("rd_pulse_t3", {31'b0, ram_rd}, 32'd0);
    goto(t + 8); check("rd_busy_t8", {31'b0, req0_rbusy}, 32'd1);
    goto(t + 9); check("rd_busy_t9", {31'b0, req0_rbusy}, 32'd0);
                 check("rd_data_t9", req0_rdata, 32'hDEADBEEF);
    check("rd_req1_untouched", req1_rdata, 32'd0);
    wait_idle("timeout_single");

    // Simultaneous strobes, minimum latency
    lat = 0;
    i0 = lg_addr.size();
    drive(1'b1, 1'b0, 20'h1, 32'h0, 1'b0, 1'b1, 20'h2, 32'h12345678, t);
    wait_idle("timeout_simul");
    check("simul_count", lg_addr.size() - i0, 32'd2);
    if (lg_addr.size() >= i0 + 2) begin
      check("simul_first_cyc", lg_cyc[i0] - t, 32'd2);
      check("simul_first_addr", {12'b0, lg_addr[i0]}, 32'h1);
      check("simul_second_cyc", lg_cyc[i0 + 1] - t, 32'd7);
      check("simul_second_wr", {31'b0, lg_wr[i0 + 1]}, 32'd1);
      check("simul_second_wdata", lg_data[i0 + 1], 32'h12345678);
    end
    check("simul_rdata0", req0_rdata, 32'hC0D00001);
    check("simul_slots_empty", {30'b0, req0_rbusy, req1_wbusy}, 32'd0);

    // Protocol violation: req1 re-strobes while its write is pending
    lat = 2;
    rp = rd_pulses; i0 = lg_addr.size();
    drive(1'b0, 1'b0, 20'h0, 32'h0, 1'b0, 1'b1, 20'h7, 32'hA5A5A5A5, t);
    req1_rd = 1'b1; req1_addr = 20'h5;
    @(posedge clk); #1;
    req1_rd = 1'b0;
    check("viol_wbusy", {31'b0, req1_wbusy}, 32'd1);
    check("viol_rbusy", {31'b0, req1_rbusy}, 32'd0);
    wait_idle("timeout_viol");
    check("viol_count", lg_addr.size() - i0, 32'd1);
    check("viol_no_rd", rd_pulses - rp, 32'd0);
    if (lg_addr.size() > i0) check("viol_addr", {12'b0, lg_addr[i0]}, 32'h7);
    drive(1'b1, 1'b0, 20'h7, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, t);
    wait_idle("timeout_viol_rb");
    check("viol_readback", req0_rdata, 32'hA5A5A5A5);

    // rd and wr together record a write
    lat = 1;
    rp = rd_pulses; wp = wr_pulses;
    drive(1'b1, 1'b1, 20'h30, 32'h0BADF00D, 1'b0, 1'b0, 20'h0, 32'h0, t);
    goto(t + 1);
    check("rdwr_wbusy", {31'b0, req0_wbusy}, 32'd1);
    check("rdwr_rbusy", {31'b0, req0_rbusy}, 32'd0);
    wait_idle("timeout_rdwr");
    check("rdwr_wr_pulses", wr_pulses - wp, 32'd1);
    check("rdwr_rd_pulses", rd_pulses - rp, 32'd0);

    // Tie resolution after different previous grants
`ifdef SPI_ARB_ROUND_ROBIN_EN
    exp_b = 1; exp_c = 1;
`else
    exp_b = 0; exp_c = 0;
`endif
    drive(1'b1, 1'b0, 20'h100, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, t);
    wait_idle("timeout_arb_a");
    i0 = lg_addr.size();
    drive(1'b1, 1'b0, 20'h101, 32'h0, 1'b1, 1'b0, 20'h201, 32'h0, t);
    wait_idle("timeout_arb_b");
    check("arb_b_count", lg_addr.size() - i0, 32'd2);
    if (lg_addr.size() > i0) check("arb_b_first", who(lg_addr[i0]), exp_b);
    i0 = lg_addr.size();
    drive(1'b1, 1'b0, 20'h102, 32'h0, 1'b1, 1'b0, 20'h202, 32'h0, t);
    wait_idle("timeout_arb_c");
    if (lg_addr.size() > i0) check("arb_c_first", who(lg_addr[i0]), exp_c);
    drive(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 20'h203, 32'h0, t);
    wait_idle("timeout_arb_d");
    i0 = lg_addr.size();
    drive(1'b1, 1'b0, 20'h104, 32'h0, 1'b1, 1'b0, 20'h204, 32'h0, t);
    wait_idle("timeout_arb_e");
    if (lg_addr.size() > i0) check("arb_e_first", who(lg_addr[i0]), 0);
    check("arb_rdata1", req1_rdata, 32'hC0D00204);

    // Reset while waiting on the controller
    lat = 6;
    drive(1'b1, 1'b0, 20'h40, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, t);
    goto(t + 5);
    check("rst_pre_busy", {31'b0, req0_rbusy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_busy", {31'b0, req0_rbusy}, 32'd0);
    check("rst_ram_rd", {31'b0, ram_rd}, 32'd0);
    check("rst_rdata0", req0_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    lat = 0;
    drive(1'b1, 1'b0, 20'h10, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, t);
    goto(t + 5); check("post_rst_busy_t5", {31'b0, req0_rbusy}, 32'd1);
    goto(t + 6); check("post_rst_busy_t6", {31'b0, req0_rbusy}, 32'd0);
                 check("post_rst_data_t6", req0_rdata, 32'hDEADBEEF);
    wait_idle("timeout_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
